// File: rtl/regfile_wb_pkg.sv
// Shared sizing and entry layout for the register-file writeback queue.
package regfile_wb_pkg;

  localparam int unsigned WB_LANES   = 6;
  localparam int unsigned SRAM_DEPTH = 128;
  localparam int unsigned SRAM_INDEX = 7;
  localparam int unsigned SRAM_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned OCC_W   = 3;
  localparam int unsigned ENTRY_W = SRAM_INDEX + SRAM_WIDTH;

  typedef struct packed {
    logic [SRAM_INDEX-1:0] tag;
    logic [SRAM_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane result FIFO: registered count, combinational head, flush clears pointers.
module wb_lane_fifo
  import regfile_wb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               ready
);

  wb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign ready = (count != CNT_W'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];

  // Storage needs no reset: nothing is read until count says it is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wb_entry_t'(din);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue: per-lane FIFOs, same-tag arbitration, registered register-file write ports.
module regfile_wb_queue
  import regfile_wb_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic [WB_LANES-1:0]              fu_valid_i,
  input  logic [WB_LANES*SRAM_INDEX-1:0]   fu_tag_i,
  input  logic [WB_LANES*SRAM_WIDTH-1:0]   fu_data_i,
  output logic [WB_LANES-1:0]              fu_ready_o,
  output logic [WB_LANES*SRAM_INDEX-1:0]   addrwr_o,
  output logic [WB_LANES-1:0]              we_o,
  output logic [WB_LANES*SRAM_WIDTH-1:0]   datawr_o,
  output logic [SRAM_DEPTH-1:0]            reg_written_o,
  output logic [WB_LANES*OCC_W-1:0]        occupancy_o
);

  logic [WB_LANES-1:0]   push;
  logic [WB_LANES-1:0]   win;
  logic [CNT_W-1:0]      count     [WB_LANES];
  logic [SRAM_INDEX-1:0] head_tag  [WB_LANES];
  logic [SRAM_WIDTH-1:0] head_data [WB_LANES];
  logic [SRAM_DEPTH-1:0] next_mask;

  for (genvar k = 0; k < WB_LANES; k++) begin : g_lane
    wb_entry_t          in_ent;
    wb_entry_t          head_ent;
    logic [ENTRY_W-1:0] head_bits;

    assign in_ent.tag  = fu_tag_i[k*SRAM_INDEX +: SRAM_INDEX];
    assign in_ent.data = fu_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
    assign push[k]     = fu_valid_i[k] & fu_ready_o[k];
    assign head_ent    = head_bits;
    assign head_tag[k]  = head_ent.tag;
    assign head_data[k] = head_ent.data;
    assign occupancy_o[k*OCC_W +: OCC_W] = OCC_W'(count[k]);

    wb_lane_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush_i),
      .push  (push[k]),
      .pop   (win[k]),
      .din   (in_ent),
      .head  (head_bits),
      .count (count[k]),
      .ready (fu_ready_o[k])
    );
  end

  // A lane issues only if no lower-numbered non-empty lane holds the same head tag.
  always_comb begin
    win       = '0;
    next_mask = '0;
    for (int unsigned k = 0; k < WB_LANES; k++) begin
      win[k] = (count[k] != '0);
      for (int unsigned j = 0; j < k; j++) begin
        if ((count[j] != '0) && (head_tag[j] == head_tag[k])) win[k] = 1'b0;
      end
      if (win[k]) next_mask[head_tag[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_o          <= '0;
      addrwr_o      <= '0;
      datawr_o      <= '0;
      reg_written_o <= '0;
    end else if (flush_i) begin
      we_o          <= '0;
      reg_written_o <= '0;
    end else begin
      we_o          <= win;
      reg_written_o <= next_mask;
      for (int unsigned k = 0; k < WB_LANES; k++) begin
        if (win[k]) begin
          addrwr_o[k*SRAM_INDEX +: SRAM_INDEX] <= head_tag[k];
          datawr_o[k*SRAM_WIDTH +: SRAM_WIDTH] <= head_data[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed plus randomized bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush_i = 1'b0;
  logic [5:0]   fu_valid_i = '0;
  logic [41:0]  fu_tag_i = '0;
  logic [191:0] fu_data_i = '0;
  logic [5:0]   fu_ready_o;
  logic [41:0]  addrwr_o;
  logic [5:0]   we_o;
  logic [191:0] datawr_o;
  logic [127:0] reg_written_o;
  logic [17:0]  occupancy_o;

  regfile_wb_queue dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .fu_valid_i    (fu_valid_i),
    .fu_tag_i      (fu_tag_i),
    .fu_data_i     (fu_data_i),
    .fu_ready_o    (fu_ready_o),
    .addrwr_o      (addrwr_o),
    .we_o          (we_o),
    .datawr_o      (datawr_o),
    .reg_written_o (reg_written_o),
    .occupancy_o   (occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t         q [6][$];
  logic [5:0]   exp_we   = '0;
  logic [41:0]  exp_addr = '0;
  logic [191:0] exp_data = '0;
  logic [127:0] exp_mask = '0;

  logic [5:0]   st_v = '0;
  logic [41:0]  st_t = '0;
  logic [191:0] st_d = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [5:0]  rdy;
    logic [17:0] occ;
    for (int k = 0; k < 6; k++) begin
      rdy[k]         = (q[k].size() < 4);
      occ[k*3 +: 3]  = 3'(q[k].size());
    end
    chk("we", 256'(we_o), 256'(exp_we));
    chk("addr", 256'(addrwr_o), 256'(exp_addr));
    chk("data", 256'(datawr_o), 256'(exp_data));
    chk("mask", 256'(reg_written_o), 256'(exp_mask));
    chk("ready", 256'(fu_ready_o), 256'(rdy));
    chk("occupancy", 256'(occupancy_o), 256'(occ));
  endtask

  // One clock edge worth of architectural behaviour, expressed on per-lane queues.
  task automatic model_step(input logic [5:0] v, input logic [41:0] t, input logic [191:0] d,
                            input logic fl);
    logic [5:0] acc;
    logic [5:0] win;
    ent_t       e;
    if (fl) begin
      for (int k = 0; k < 6; k++) q[k].delete();
      exp_we   = '0;
      exp_mask = '0;
      return;
    end
    for (int k = 0; k < 6; k++) acc[k] = v[k] && (q[k].size() < 4);
    for (int k = 0; k < 6; k++) begin
      win[k] = (q[k].size() > 0);
      for (int j = 0; j < k; j++)
        if (q[j].size() > 0 && q[k].size() > 0 && q[j][0].tag == q[k][0].tag) win[k] = 1'b0;
    end
    exp_we   = win;
    exp_mask = '0;
    for (int k = 0; k < 6; k++) begin
      if (win[k]) begin
        e = q[k].pop_front();
        exp_addr[k*7 +: 7]   = e.tag;
        exp_data[k*32 +: 32] = e.data;
        exp_mask[e.tag]      = 1'b1;
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (acc[k]) begin
        e.tag  = t[k*7 +: 7];
        e.data = d[k*32 +: 32];
        q[k].push_back(e);
      end
    end
  endtask

  task automatic stage(input int k, input logic [6:0] tag, input logic [31:0] data);
    st_v[k]         = 1'b1;
    st_t[k*7 +: 7]  = tag;
    st_d[k*32 +: 32] = data;
  endtask

  task automatic go(input logic fl);
    fu_valid_i = st_v;
    fu_tag_i   = st_t;
    fu_data_i  = st_d;
    flush_i    = fl;
    model_step(st_v, st_t, st_d, fl);
    @(posedge clk);
    @(negedge clk);
    st_v       = '0;
    fu_valid_i = '0;
    flush_i    = 1'b0;
    check_all();
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    check_all();
    chk("reset_ready", 256'(fu_ready_o), 256'(6'b111111));
    go(1'b0);

    // Single write, two-cycle latency.
    stage(0, 7'd5, 32'hDEADBEEF);
    go(1'b0);
    chk("lat_we_early", 256'(we_o), 256'(6'b000000));
    go(1'b0);
    chk("lat_we", 256'(we_o), 256'(6'b000001));
    chk("lat_addr0", 256'(addrwr_o[6:0]), 256'(7'd5));
    chk("lat_data0", 256'(datawr_o[31:0]), 256'(32'hDEADBEEF));
    chk("lat_mask", 256'(reg_written_o), 256'(128'd1 << 5));
    go(1'b0);
    chk("lat_we_off", 256'(we_o), 256'(6'b000000));

    // Back-to-back pushes on lane 3.
    for (int i = 0; i < 6; i++) begin
      stage(3, 7'(10 + i), $urandom);
      go(1'b0);
    end
    repeat (3) go(1'b0);

    // Same-tag conflict between lanes 1 and 4.
    stage(1, 7'd100, 32'h11111111);
    stage(4, 7'd100, 32'h44444444);
    go(1'b0);
    go(1'b0);
    chk("conf_first", 256'(we_o), 256'(6'b000010));
    go(1'b0);
    chk("conf_second", 256'(we_o), 256'(6'b010000));
    go(1'b0);

    // Lane 2 head held behind lane 0 until full, then drains.
    for (int i = 0; i < 8; i++) begin
      stage(0, 7'd20, $urandom);
      stage(2, (i == 0) ? 7'd20 : 7'(30 + i), $urandom);
      go(1'b0);
    end
    chk("full_occ2", 256'(occupancy_o[8:6]), 256'(3'd4));
    chk("full_ready2", 256'(fu_ready_o[2]), 256'(1'b0));
    repeat (6) go(1'b0);
    chk("drain_occ2", 256'(occupancy_o[8:6]), 256'(3'd0));

    // Flush with three entries queued on lane 5.
    for (int i = 0; i < 3; i++) begin
      stage(0, 7'd40, $urandom);
      stage(5, (i == 0) ? 7'd40 : 7'(50 + i), $urandom);
      go(1'b0);
    end
    chk("pre_flush_occ5", 256'(occupancy_o[17:15]), 256'(3'd3));
    stage(5, 7'd60, 32'h5);
    go(1'b1);
    chk("flush_occ", 256'(occupancy_o), 256'(18'd0));
    chk("flush_we", 256'(we_o), 256'(6'b000000));
    repeat (3) go(1'b0);

    // Randomized traffic with a narrow tag range to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 99) < 60)
          stage(k, ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)), $urandom);
      end
      go($urandom_range(0, 49) == 0);
    end
    repeat (6) go(1'b0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 6; k++) stage(k, 7'd9, $urandom);
      go(1'b0);
    end
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) q[k].delete();
    exp_we   = '0;
    exp_addr = '0;
    exp_data = '0;
    exp_mask = '0;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    check_all();
    stage(2, 7'd77, 32'hCAFEF00D);
    go(1'b0);
    go(1'b0);
    go(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writeback-side driver for the banked 128-entry physical register file.
- Accepts results from up to 6 functional-unit lanes over valid/ready handshakes and buffers each lane in a small FIFO.
- Drives the register file write ports (addrNwr, weN, dataNwr) from registered outputs, with same-register conflict arbitration.
- Broadcasts a one-hot "register written" mask to the issue scheduler.

Parameters:
- WB_LANES, 6, number of writeback lanes; equals the register file write-port count.
- SRAM_DEPTH, 128, physical registers.
- SRAM_INDEX, 7, physical register tag width.
- SRAM_WIDTH, 32, data width.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: state clears immediately when reset=0; release is synchronous to clk.
- flush_i  in  1  pipeline flush; drops all queued and in-flight writes.
- fu_valid_i  in  WB_LANES  per-lane result valid.
- fu_tag_i  in  WB_LANES*SRAM_INDEX  per-lane destination tag; lane k occupies bits [k*SRAM_INDEX +: SRAM_INDEX].
- fu_data_i  in  WB_LANES*SRAM_WIDTH  per-lane result data.
- fu_ready_o  out  WB_LANES  per-lane FIFO can accept.
- addrwr_o  out  WB_LANES*SRAM_INDEX  register file write addresses.
- we_o  out  WB_LANES  register file write enables.
- datawr_o  out  WB_LANES*SRAM_WIDTH  register file write data.
- reg_written_o  out  SRAM_DEPTH  mask of registers written this cycle; equals OR of decoded addrwr_o over lanes with we_o=1.
- occupancy_o  out  WB_LANES*3  per-lane FIFO count, 0..FIFO_DEPTH.

Behaviour:
- Reset (reset=0): all FIFOs empty, counts 0, pointers 0, we_o=0, addrwr_o=0, datawr_o=0, reg_written_o=0, fu_ready_o all 1 once reset is released.
- Push: lane k pushes when fu_valid_i[k] & fu_ready_o[k] at a rising edge.
- fu_ready_o[k] = (count[k] != FIFO_DEPTH). It is a function of registered count only and never depends on the same-cycle pop.
- Simultaneous push and pop on a full FIFO is not possible, because ready=0. On a non-full FIFO, simultaneous push and pop leaves the count unchanged.
- Issue candidate: lane k is a candidate when count[k] != 0. Its head entry is read combinationally.
- Conflict rule: if candidate lanes j<k hold equal head tags, only the lowest-numbered lane issues that cycle. Higher lanes hold their heads and retry next cycle. No two we_o bits are ever high with equal addrwr_o.
- Pop: a winning lane pops its head; the head's tag and data are registered into addrwr_o, datawr_o and we_o[k]=1 on the same edge.
- Non-winning lanes, and lanes with empty FIFOs, register we_o[k]=0. addrwr_o and datawr_o for those lanes hold their previous value.
- Latency: a result pushed at edge t into an empty lane with no conflict appears with we_o=1 after edge t+1, i.e. 2 cycles. There is no input-to-output bypass.
- Throughput: 1 write per lane per cycle when conflict-free.
- Ordering: strict FIFO order within a lane; no ordering guarantee across lanes.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is tracked separately, with width log2(FIFO_DEPTH)+1.
- reg_written_o is registered alongside we_o and is consistent with it in the same cycle.
- Flush: if flush_i=1 at edge t, all counts and pointers go to 0 and we_o=0, reg_written_o=0 after t. Pushes and pops in that cycle are discarded, and flush takes priority over both.
- Reset mid-operation: outputs clear asynchronously; queued data is lost.

Decomposition:
- Package regfile_wb_pkg: WB_LANES, SRAM_INDEX, SRAM_WIDTH, SRAM_DEPTH, FIFO_DEPTH, pointer and count widths, lane entry struct {tag, data}.
- Sub-module wb_lane_fifo: one instance per lane via generate, with push/pop/flush, count, head output, and the same reset.
- The top level holds the conflict arbiter, output registers and mask decode.

Test Plan:
- Reset held low, then released -> we_o=0, reg_written_o=0, fu_ready_o=6'b111111, occupancy all 0.
- Lane 0 push tag 7'd5, data 32'hDEADBEEF at edge 1 -> after edge 2: we_o=6'b000001, addrwr_o lane0=5, datawr_o lane0=DEADBEEF, reg_written_o=1<<5; one cycle later we_o=0.
- Lane 3 given 6 back-to-back valid pushes, no pops blocked -> pushes accepted; writes emitted in push order, one per cycle; fu_ready_o[3] never drops below 1 except when occupancy_o lane3=4.
- Lanes 1 and 4 push tag 7'd100 in the same cycle -> lane 1 writes first (we_o=6'b000010), lane 4 writes the next cycle (we_o=6'b010000); they are never high together.
- Fill lane 2 to 4 entries by holding its head behind a lane-0 conflict on the same tag -> fu_ready_o[2]=0 with fu_valid_i[2]=1 causes no push and occupancy stays 4; after the conflict clears, occupancy drains 4,3,2,1,0.
- flush_i=1 with 3 entries queued in lane 5 -> next cycle occupancy 0, we_o=0; no lane-5 write is ever emitted.
